int_ctrl: RTL and testbench

External interrupt controller that conditions the six raw hardware interrupt lines before they reach the `int_i` input of the CP0 register block. Per line, it performs:
- polarity selection;
- multi-flop synchronisation;
- glitch filtering;
- level- or edge-mode capture with per-line masking.

The result is presented as a 6-bit pending vector, `int_o`, to CP0. A small register file lets software read status and configure the controller. The read and write port uses the same naming and timing as the CP0 register port. The CPU reaches it through the memory-mapped peripheral path.

---
 rtl/int_ctrl.sv | 131 +++++++++++++
 tb/tb_int_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// External interrupt conditioner in front of CP0 int_i. Each raw line is polarity-adjusted,
// synchronised, glitch-filtered and captured in level or edge mode. A small register file configures it.

module int_line #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic irq_i,
   input  logic pol_i,
   input  logic mode_i,
   input  logic clr_i,
   output logic filt_o,
   output logic pend_o
);
   localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   filt_prev_q;
   logic                   pend_q, pend_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (s == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         filt_d = s;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
      // edge mode: a fresh filtered rise beats a simultaneous clear
      pend_d = mode_i ? ((pend_q & ~clr_i) | (filt_q & ~filt_prev_q)) : filt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_i ^ pol_i};
         cnt_q       <= cnt_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         pend_q      <= pend_d;
      end
   end

   assign filt_o = filt_q;
   assign pend_o = pend_q;
endmodule

module int_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  irq_i,
   input  logic        timer_int_i,
   input  logic        we_i,
   input  logic [2:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] data_o,
   output logic [5:0]  int_o
);
   localparam int NUM_LINES = 6;

   logic [NUM_LINES-1:0] mask_q, mode_q, pol_q;
   logic [NUM_LINES-1:0] filt, pend, clr;
   logic                 unused_wdata;

   assign unused_wdata = ^wdata_i[31:NUM_LINES];
   assign clr = (we_i && addr_i == 3'd5) ? wdata_i[NUM_LINES-1:0] : '0;

   for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      int_line #(
         .SYNC_STAGES(SYNC_STAGES),
         .FILTER_LEN (FILTER_LEN)
      ) u_line (
         .clk   (clk),
         .rst   (rst),
         .irq_i (irq_i[i]),
         .pol_i (pol_q[i]),
         .mode_i(mode_q[i]),
         .clr_i (clr[i]),
         .filt_o(filt[i]),
         .pend_o(pend[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
         mode_q <= '0;
         pol_q  <= '0;
      end else if (we_i) begin
         case (addr_i)
            3'd2:    mask_q <= wdata_i[NUM_LINES-1:0];
            3'd3:    mode_q <= wdata_i[NUM_LINES-1:0];
            3'd4:    pol_q  <= wdata_i[NUM_LINES-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      data_o = '0;
      case (addr_i)
         3'd0:    data_o[NUM_LINES-1:0] = filt;
         3'd1:    data_o[NUM_LINES-1:0] = pend;
         3'd2:    data_o[NUM_LINES-1:0] = mask_q;
         3'd3:    data_o[NUM_LINES-1:0] = mode_q;
         3'd4:    data_o[NUM_LINES-1:0] = pol_q;
         default: data_o = '0;
      endcase
   end

   // the CP0 timer shares line 5 and skips conditioning entirely
   assign int_o = mask_q & {pend[5] | timer_int_i, pend[4:0]};
endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: int_o expectations are queued with their due edge and checked on negedges.

module tb_int_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  irq_i = '0;
   logic        timer_int_i = 1'b0;
   logic        we_i = 1'b0;
   logic [2:0]  addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] data_o;
   logic [5:0]  int_o;

   int total = 0;
   int bad   = 0;
   int ne    = 0;

   typedef struct {
      int         due;
      logic [5:0] val;
      string      tag;
   } exp_t;
   exp_t sb[$];

   int_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .irq_i      (irq_i),
      .timer_int_i(timer_int_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .data_o     (data_o),
      .int_o      (int_o)
   );

   always #20 clk = ~clk;
   always @(posedge clk) ne <= ne + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input int due, input logic [5:0] val, input string tag);
      exp_t e;
      e.due = due;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= ne) begin
         if (sb[0].due == ne) chk(sb[0].tag, {26'd0, int_o}, {26'd0, sb[0].val});
         else chk({sb[0].tag, "_late"}, ne, sb[0].due);
         void'(sb.pop_front());
      end
   end

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we_i = 1'b1;
      addr_i = a;
      wdata_i = d;
      tick();
      we_i = 1'b0;
      wdata_i = '0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [5:0] e, input string tag);
      addr_i = a;
      #1;
      chk(tag, data_o, {26'd0, e});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tick(3);
      chk("rst_int", {26'd0, int_o}, 32'd0);
      for (int a = 0; a < 8; a++) rd(3'(a), 6'h00, "rst_rd");
      rst = 1'b0;
      tick();

      // level mode assertion/deassertion latency on line 0
      wr(3'd2, 32'hFFFF_FF3F);
      wr(3'd3, 32'd0);
      wr(3'd4, 32'd0);
      rd(3'd2, 6'h3F, "mask_rd");
      irq_i[0] = 1'b1; n = ne;
      push(n + 5, 6'h00, "t1_pre");
      push(n + 6, 6'h01, "t1_rise");
      tick(6);
      irq_i[0] = 1'b0; n = ne;
      push(n + 5, 6'h01, "t1_hold");
      push(n + 6, 6'h00, "t1_fall");
      tick(7);

      // glitch filter: 2-cycle pulse dropped, 3-cycle pulse passes
      irq_i[2] = 1'b1; n = ne;
      for (int k = 1; k <= 9; k++) push(n + k, 6'h00, "t2_short");
      tick(2);
      irq_i[2] = 1'b0;
      tick(8);
      rd(3'd1, 6'h00, "t2_short_pend");
      irq_i[2] = 1'b1; n = ne;
      push(n + 5, 6'h00, "t2_pre");
      push(n + 6, 6'h04, "t2_rise");
      push(n + 8, 6'h04, "t2_hold");
      push(n + 9, 6'h00, "t2_fall");
      tick(3);
      irq_i[2] = 1'b0;
      tick(7);

      // edge mode on line 1: sticky, CLR, set beats clear
      wr(3'd3, 32'h02);
      irq_i[1] = 1'b1; n = ne;
      push(n + 5, 6'h00, "t3_pre");
      push(n + 6, 6'h02, "t3_rise");
      tick(6);
      irq_i[1] = 1'b0; n = ne;
      push(n + 6, 6'h02, "t3_sticky");
      tick(7);
      rd(3'd1, 6'h02, "t3_pend");
      rd(3'd0, 6'h00, "t3_filt_low");
      wr(3'd5, 32'h02);
      rd(3'd1, 6'h00, "t3_clr");
      rd(3'd5, 6'h00, "clr_rd0");
      irq_i[1] = 1'b1;
      tick(5);
      wr(3'd5, 32'h02);
      rd(3'd1, 6'h02, "t3_set_wins");
      irq_i[1] = 1'b0;
      tick(7);
      wr(3'd5, 32'h02);
      rd(3'd1, 6'h00, "t3_clr2");

      // active-low line 3, then masked while pending
      wr(3'd4, 32'h08);
      irq_i[3] = 1'b1;
      tick(8);
      rd(3'd1, 6'h00, "t4_inactive");
      irq_i[3] = 1'b0; n = ne;
      push(n + 5, 6'h00, "t4_pre");
      push(n + 6, 6'h08, "t4_rise");
      tick(6);
      rd(3'd0, 6'h08, "t4_filt");
      wr(3'd2, 32'h37);
      rd(3'd1, 6'h08, "t4_pend_masked");
      push(ne, 6'h00, "t4_masked");
      tick();

      // timer bypass
      timer_int_i = 1'b1;
      push(ne, 6'h20, "t5_timer");
      tick();
      wr(3'd2, 32'h17);
      push(ne, 6'h00, "t5_timer_masked");
      tick();
      timer_int_i = 1'b0;

      // reset with state pending and a line mid-filter
      wr(3'd2, 32'h3F);
      irq_i[1] = 1'b1; n = ne;
      push(n + 5, 6'h08, "t6_pre");
      push(n + 6, 6'h0A, "t6_pend");
      tick(6);
      rd(3'd3, 6'h02, "t6_mode");
      rd(3'd4, 6'h08, "t6_pol");
      irq_i[4] = 1'b1;
      tick(2);
      rst = 1'b1;
      irq_i = '0;
      tick();
      rst = 1'b0;
      for (int a = 0; a < 8; a++) rd(3'(a), 6'h00, "t6_rd");
      n = ne;
      for (int k = 0; k <= 8; k++) push(n + k, 6'h00, "t6_int");
      tick(9);
      wr(3'd6, 32'hFF);
      wr(3'd7, 32'hFF);
      rd(3'd6, 6'h00, "a6_rd");
      rd(3'd7, 6'h00, "a7_rd");
      rd(3'd2, 6'h00, "a6_no_alias");

      tick(3);
      chk("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
